nx_node_data_arbiter: RTL
=========================

NX_NODE_DATA_ARBITER -- requirements
Module: nx_node_data_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, inbound request buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 16, consecutive blocked cycles before starvation is flagged.
REQ-003 SHALL use one clock and an asynchronous active-high reset: i_clk  input  1  clock; i_rst  input  1  async reset, active-high.
REQ-004 SHALL have i_core_addr  input  10  core data RAM row.
REQ-005 SHALL have i_core_wr_data  input  32  core write data.
REQ-006 SHALL have i_core_wr_strb  input  32  core per-bit write strobe.
REQ-007 SHALL have i_core_rd_en  input  1  core read request.
REQ-008 SHALL have o_core_rd_data  output  32  core read data, one cycle after request.
REQ-009 SHALL have i_in_addr, i_in_wr_data, i_in_wr_strb  input  10/32/32  inbound message access.
REQ-010 SHALL have i_in_rd_en  input  1  inbound access is a read (strobe ignored).
REQ-011 SHALL have i_in_valid  input  1 and o_in_ready  output  1  inbound valid/ready handshake.
REQ-012 SHALL have o_in_rd_data  output  32 and o_in_rd_valid  output  1  inbound read response.
REQ-013 SHALL have o_ram_addr, o_ram_wr_data, o_ram_wr_strb, o_ram_rd_en  output  10/32/32/1 and i_ram_rd_data  input  32  single-port RAM, 1-cycle read latency.
REQ-014 SHALL have o_idle  output  1  FIFO empty and no read outstanding.
REQ-015 SHALL have o_starve  output  1  inbound traffic starved by core.

Function
REQ-016 Core access = i_core_rd_en or any i_core_wr_strb bit set; core access SHALL always win the RAM, driven combinationally same cycle.
REQ-017 Inbound transfer SHALL be accepted on i_in_valid && o_in_ready and pushed into the FIFO (addr, data, strb, rd_en).
REQ-018 o_in_ready SHALL equal (occupancy < FIFO_DEPTH) from registered occupancy; no push at full even if popping same cycle.
REQ-019 FIFO head SHALL be issued to RAM and popped in any cycle with no core access and FIFO non-empty; earliest issue is the cycle after acceptance (no bypass).
REQ-020 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 With no core access and empty FIFO, RAM outputs SHALL be zero (rd_en 0, strb 0, addr 0, data 0).
REQ-022 o_core_rd_data SHALL equal i_ram_rd_data unconditionally; valid only the cycle after a core read.
REQ-023 o_in_rd_valid SHALL assert exactly one cycle after an inbound read is issued, o_in_rd_data = i_ram_rd_data then, else o_in_rd_data = 0.
REQ-024 Ordering: inbound accesses SHALL issue in acceptance order; no ordering or forwarding between core and buffered inbound accesses to the same row.
REQ-025 Starve counter SHALL increment (saturating at STARVE_LIMIT) each cycle FIFO non-empty and head blocked by core access; clears on any pop.
REQ-026 o_starve SHALL be registered: set when counter reaches STARVE_LIMIT, held until FIFO becomes empty.
REQ-027 o_idle SHALL be registered-derived: occupancy == 0 and no inbound read outstanding.

Reset
REQ-028 During reset: occupancy 0, pointers 0, starve counter 0, o_starve 0, o_in_rd_valid 0, o_idle 1, o_in_ready 1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries and any outstanding inbound read response.

Verification
REQ-030 Idle core, inbound write addr 0x005 strb 0x0000FF00 at cycle N -> RAM write issued N+1, o_idle 1 from N+2.
REQ-031 Core read every cycle, 4 inbound pushes -> o_in_ready 0 after 4th, no RAM inbound issue, o_starve 1 after 16 blocked cycles; core stops -> 4 issues in order, o_starve 0 after drain.
REQ-032 Inbound read of row 0x3FF, RAM returns 0xDEADBEEF -> o_in_rd_valid pulse 1 cycle with that data, following issue cycle.
REQ-033 FIFO full with push and pop same cycle -> push refused, occupancy 3 next cycle, ready 1.
REQ-034 Reset asserted with 3 entries buffered and read outstanding -> no further RAM inbound issue, o_in_rd_valid 0, o_idle 1.

Source files
------------

// File: rtl/nx_node_data_arbiter.sv
// Arbitrates a single-port data RAM between the core (always wins) and a buffered
// inbound message port; tracks inbound starvation and read responses.
module nx_node_data_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [9:0]  i_core_addr,
    input  logic [31:0] i_core_wr_data,
    input  logic [31:0] i_core_wr_strb,
    input  logic        i_core_rd_en,
    output logic [31:0] o_core_rd_data,

    input  logic [9:0]  i_in_addr,
    input  logic [31:0] i_in_wr_data,
    input  logic [31:0] i_in_wr_strb,
    input  logic        i_in_rd_en,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [31:0] o_in_rd_data,
    output logic        o_in_rd_valid,

    output logic [9:0]  o_ram_addr,
    output logic [31:0] o_ram_wr_data,
    output logic [31:0] o_ram_wr_strb,
    output logic        o_ram_rd_en,
    input  logic [31:0] i_ram_rd_data,

    output logic        o_idle,
    output logic        o_starve
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [OW-1:0] DEPTH_OCC  = OW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Entry storage carries no reset: occupancy alone decides what is valid.
    logic [9:0]  fifo_addr [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [31:0] fifo_strb [FIFO_DEPTH];
    logic        fifo_rd   [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starve_q, starve_d;
    logic          in_rd_pend_q, in_rd_pend_d;

    logic          core_access;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [9:0]    head_addr;
    logic [31:0]   head_data;
    logic [31:0]   head_strb;
    logic          head_rd;

    assign core_access = i_core_rd_en | (|i_core_wr_strb);
    assign fifo_empty  = (occ_q == '0);

    // Ready comes from registered occupancy only, so a full FIFO refuses a push
    // even in a cycle where it also pops.
    assign o_in_ready  = (occ_q < DEPTH_OCC);
    assign push        = i_in_valid & o_in_ready;
    assign pop         = ~core_access & ~fifo_empty;

    assign head_addr   = fifo_addr[rd_ptr_q];
    assign head_data   = fifo_data[rd_ptr_q];
    assign head_strb   = fifo_strb[rd_ptr_q];
    assign head_rd     = fifo_rd[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= i_in_addr;
            fifo_data[wr_ptr_q] <= i_in_wr_data;
            fifo_strb[wr_ptr_q] <= i_in_wr_strb;
            fifo_rd[wr_ptr_q]   <= i_in_rd_en;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // RAM port mux: core first, then FIFO head, otherwise fully quiet.
    always_comb begin
        o_ram_addr    = '0;
        o_ram_wr_data = '0;
        o_ram_wr_strb = '0;
        o_ram_rd_en   = 1'b0;
        if (core_access) begin
            o_ram_addr    = i_core_addr;
            o_ram_wr_data = i_core_wr_data;
            o_ram_wr_strb = i_core_wr_strb;
            o_ram_rd_en   = i_core_rd_en;
        end else if (pop) begin
            o_ram_addr    = head_addr;
            o_ram_wr_data = head_data;
            o_ram_wr_strb = head_rd ? '0 : head_strb;
            o_ram_rd_en   = head_rd;
        end
    end

    assign in_rd_pend_d = pop & head_rd;

    // Counts cycles the head waits behind the core; any pop restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop) begin
            starve_cnt_d = '0;
        end else if (!fifo_empty && core_access && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    // The flag outlives the counter clear on pop and drops only once drained.
    always_comb begin
        if (occ_d == '0) begin
            starve_d = 1'b0;
        end else begin
            starve_d = starve_q | (starve_cnt_d == STARVE_MAX);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
            in_rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
            in_rd_pend_q <= in_rd_pend_d;
        end
    end

    assign o_core_rd_data = i_ram_rd_data;
    assign o_in_rd_valid  = in_rd_pend_q;
    assign o_in_rd_data   = in_rd_pend_q ? i_ram_rd_data : '0;
    assign o_idle         = fifo_empty & ~in_rd_pend_q;
    assign o_starve       = starve_q;

    occ_bound_a : assert property (@(posedge i_clk) disable iff (i_rst) occ_q <= DEPTH_OCC);

endmodule
